// File: rtl/loader_pkg.sv
// Shared constants and state encoding for the boot-time RAM loader.
package loader_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int RAM_DEPTH  = 2 ** ADDR_W_DEF;

  // Loader FSM states; the encoding is also exported on the state port.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_BYTE = 3'd1,
    ST_ADDR      = 3'd2,
    ST_WRITE     = 3'd3,
    ST_RELEASE   = 3'd4,
    ST_RUN       = 3'd5
  } state_t;

endpackage

// File: rtl/ram_loader.sv
// Boot-time loader: owns the CPU bus while host bytes are written into RAM
// (MAR write via mi, then RAM write via ri), then pulses CPU reset and lets
// the CPU run.
//
// Host stream handshake: a byte is transferred on a rising edge where
// in_valid and in_ready are both high. in_ready depends only on state (high
// in WAIT_BYTE only); the host must hold in_data/in_valid stable until the
// transfer happens, and a byte offered while in_ready is low is not consumed.
module ram_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              bus_oe,
  output logic [DATA_W-1:0] bus_out,
  output logic              mi,
  output logic              ri,
  output logic              cpu_hold,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output state_t            state
);

  localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W + 1)'(2 ** ADDR_W);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   len;
  logic [DATA_W-1:0] byte_q;
  logic [ADDR_W:0]   len_clamped;
  logic              last_byte;

  // Clamp the requested length so the final write lands on the top address
  // and the address counter never wraps back to 0.
  always_comb begin
    len_clamped = load_len;
    if (load_len > DEPTH) len_clamped = DEPTH;
    last_byte = ((count + CNT_ONE) == len);
  end

  // Loader FSM; every output is set on the edge that enters its state, so
  // all outputs are plain registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      addr     <= '0;
      count    <= '0;
      len      <= '0;
      byte_q   <= '0;
      in_ready <= 1'b0;
      bus_oe   <= 1'b0;
      bus_out  <= '0;
      mi       <= 1'b0;
      ri       <= 1'b0;
      cpu_hold <= 1'b1;
      cpu_rst  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      mi      <= 1'b0;
      ri      <= 1'b0;
      bus_oe  <= 1'b0;
      bus_out <= '0;
      cpu_rst <= 1'b0;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            len   <= len_clamped;
            addr  <= '0;
            count <= '0;
            busy  <= 1'b1;
            if (len_clamped == '0) begin
              state   <= ST_RELEASE;
              cpu_rst <= 1'b1;
            end else begin
              state    <= ST_WAIT_BYTE;
              in_ready <= 1'b1;
            end
          end
        end
        ST_WAIT_BYTE: begin
          if (in_valid && in_ready) begin
            byte_q   <= in_data;
            in_ready <= 1'b0;
            state    <= ST_ADDR;
            bus_oe   <= 1'b1;
            bus_out  <= DATA_W'(addr);
            mi       <= 1'b1;
          end
        end
        ST_ADDR: begin
          state   <= ST_WRITE;
          bus_oe  <= 1'b1;
          bus_out <= byte_q;
          ri      <= 1'b1;
        end
        ST_WRITE: begin
          if (last_byte) begin
            state   <= ST_RELEASE;
            cpu_rst <= 1'b1;
          end else begin
            addr     <= addr + ADDR_ONE;
            count    <= count + CNT_ONE;
            state    <= ST_WAIT_BYTE;
            in_ready <= 1'b1;
          end
        end
        ST_RELEASE: begin
          state    <= ST_RUN;
          cpu_hold <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b1;
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: scoreboard of expected {addr, data}
// RAM writes plus per-scenario timing and output checks.
module tb_ram_loader;
  import loader_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int W  = AW + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   load_len = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, bus_oe, mi, ri, cpu_hold, cpu_rst, busy, done;
  logic [DW-1:0] bus_out;
  state_t        state;

  ram_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .bus_oe(bus_oe), .bus_out(bus_out), .mi(mi), .ri(ri),
    .cpu_hold(cpu_hold), .cpu_rst(cpu_rst), .busy(busy), .done(done),
    .state(state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Packed view of every output, for whole-vector reset checks
  logic [18:0] outs;
  assign outs = {state, in_ready, bus_oe, bus_out, mi, ri, cpu_hold, cpu_rst, busy, done};
  localparam logic [18:0] RST_OUTS = {ST_IDLE, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] host_q[$];
  int acc_cyc[$];

  int wr_count, last_ri_cyc, cpu_rst_cyc, done_cyc, rst_pulses, done_pulses, acc_count;
  logic hold_at_done, mi_seen, last_acc, last_rdy;
  logic [AW-1:0] mi_addr;

  // Bus monitor: pairs each mi address with the following ri data and checks
  // it against the scoreboard; also checks bus ownership invariants.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_oe || mi || ri) begin
        n_tests++;
        if ((mi && ri) || (bus_oe !== (mi || ri))) begin
          n_fail++;
          $display("FAIL bus_ctrl cyc=%0d got bus_oe=%b mi=%b ri=%b want bus_oe=mi|ri and not mi&ri",
                   cyc, bus_oe, mi, ri);
        end
      end else if (bus_out !== '0) begin
        n_fail++;
        $display("FAIL bus_idle cyc=%0d got bus_out=%h want 00", cyc, bus_out);
      end
      if (mi) begin
        mi_addr = bus_out[AW-1:0];
        mi_seen = 1'b1;
        if (bus_out[DW-1:AW] !== '0) begin
          n_fail++;
          $display("FAIL mi_upper cyc=%0d got bus_out=%h want upper bits 0", cyc, bus_out);
        end
      end
      if (ri) begin
        n_tests++;
        if (!mi_seen || exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write cyc=%0d got addr=%h data=%h mi_seen=%b want no write",
                   cyc, mi_addr, bus_out, mi_seen);
        end else begin
          logic [W-1:0] exp_w;
          exp_w = exp_q.pop_front();
          if ({mi_addr, bus_out} !== exp_w) begin
            n_fail++;
            $display("FAIL write cyc=%0d got addr/data=%h want %h", cyc, {mi_addr, bus_out}, exp_w);
          end
        end
        mi_seen = 1'b0;
        wr_count++;
        last_ri_cyc = cyc;
      end
      if (cpu_rst) begin rst_pulses++; cpu_rst_cyc = cyc; end
      if (done) begin done_pulses++; done_cyc = cyc; hold_at_done = cpu_hold; end
    end
  end

  // Driver tasks
  task automatic clear_sb();
    exp_q.delete(); host_q.delete(); acc_cyc.delete();
    wr_count = 0; last_ri_cyc = -1; cpu_rst_cyc = -1; done_cyc = -1;
    rst_pulses = 0; done_pulses = 0; acc_count = 0;
    hold_at_done = 1'b1; mi_seen = 1'b0; mi_addr = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_sb();
  endtask

  task automatic start_load(input int len);
    load_len = (AW + 1)'(len);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // One host cycle: present (v, d), record whether the byte transfers.
  task automatic host_cycle(input logic v, input logic [DW-1:0] d);
    in_valid = v;
    in_data  = d;
    @(negedge clk);
    last_rdy = in_ready;
    last_acc = in_valid && in_ready;
    if (last_acc) begin acc_count++; acc_cyc.push_back(cyc); end
    @(posedge clk);
    #1;
    if (last_acc && host_q.size() > 0) void'(host_q.pop_front());
  endtask

  // Stream host_q until the CPU is released or the cycle budget runs out.
  task automatic stream_until_done(input int budget, input string name);
    for (int i = 0; i < budget && done_pulses == 0; i++) begin
      if (host_q.size() > 0) host_cycle(1'b1, host_q[0]);
      else host_cycle(1'b0, 8'(($urandom_range(0, 255))));
    end
    n_tests++;
    if (done_pulses != 1) begin
      n_fail++;
      $display("FAIL %s_timeout got done_pulses=%0d want 1", name, done_pulses);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_tests++;
      if (outs !== RST_OUTS) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got outs=%h want %h", cyc, outs, RST_OUTS);
      end
    end
  endtask

  task automatic test_stream3();
    logic [DW-1:0] bytes [3];
    bytes = '{8'h1E, 8'h2F, 8'hE0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({AW'(i), bytes[i]});
      host_q.push_back(bytes[i]);
    end
    start_load(3);
    stream_until_done(40, "stream3");
    n_tests++;
    if (wr_count != 3 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream3_writes got writes=%0d left=%0d want 3 and 0", wr_count, exp_q.size());
    end
    n_tests++;
    if (acc_cyc.size() != 3 || acc_cyc[1] - acc_cyc[0] != 3 || acc_cyc[2] - acc_cyc[1] != 3) begin
      n_fail++;
      $display("FAIL stream3_spacing got accepts=%0d want 3 accepts 3 cycles apart", acc_cyc.size());
    end
    n_tests++;
    if (cpu_rst_cyc != last_ri_cyc + 1 || rst_pulses != 1) begin
      n_fail++;
      $display("FAIL stream3_cpu_rst got cyc=%0d pulses=%0d want cyc=%0d pulses=1",
               cpu_rst_cyc, rst_pulses, last_ri_cyc + 1);
    end
    n_tests++;
    if (done_cyc != cpu_rst_cyc + 1 || hold_at_done !== 1'b0) begin
      n_fail++;
      $display("FAIL stream3_done got cyc=%0d hold=%b want cyc=%0d hold=0",
               done_cyc, hold_at_done, cpu_rst_cyc + 1);
    end
    // start in RUN is ignored; done is a single pulse
    start_load(3);
    @(negedge clk);
    n_tests++;
    if (state !== ST_RUN || done !== 1'b0 || cpu_hold !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL run_hold got state=%0d done=%b hold=%b rdy=%b busy=%b want 5 0 0 0 0",
               state, done, cpu_hold, in_ready, busy);
    end
  endtask

  task automatic test_valid_toggle();
    do_reset();
    exp_q.push_back({AW'(0), 8'hA1});
    exp_q.push_back({AW'(1), 8'hB2});
    start_load(2);
    host_cycle(1'b1, 8'hA1);
    n_tests++;
    if (acc_count != 1) begin
      n_fail++;
      $display("FAIL toggle_first_accept got accepts=%0d want 1", acc_count);
    end
    repeat (2) host_cycle(1'b0, 8'(($urandom_range(0, 255))));
    for (int i = 0; i < 4; i++) begin
      host_cycle(1'b0, 8'(($urandom_range(0, 255))));
      n_tests++;
      if (last_rdy !== 1'b1 || acc_count != 1) begin
        n_fail++;
        $display("FAIL toggle_wait got in_ready=%b accepts=%0d want 1 and 1", last_rdy, acc_count);
      end
    end
    host_q.push_back(8'hB2);
    stream_until_done(30, "toggle");
    n_tests++;
    if (acc_count != 2 || wr_count != 2 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL toggle_writes got accepts=%0d writes=%0d left=%0d want 2 2 0",
               acc_count, wr_count, exp_q.size());
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      logic [DW-1:0] b;
      b = 8'($urandom_range(0, 255));
      host_q.push_back(b);
      if (i < RAM_DEPTH) exp_q.push_back({AW'(i), b});
    end
    start_load(20);
    stream_until_done(120, "overflow");
    n_tests++;
    if (acc_count != 16 || wr_count != 16 || host_q.size() != 4 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL overflow_count got accepts=%0d writes=%0d host_left=%0d exp_left=%0d want 16 16 4 0",
               acc_count, wr_count, host_q.size(), exp_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      host_cycle(1'b1, host_q[0]);
      n_tests++;
      if (last_rdy !== 1'b0 || last_acc || state !== ST_RUN) begin
        n_fail++;
        $display("FAIL overflow_excess got in_ready=%b state=%0d want 0 and 5", last_rdy, state);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_len_zero();
    do_reset();
    start_load(0);
    @(negedge clk);
    n_tests++;
    if (state !== ST_RELEASE || cpu_rst !== 1'b1 || cpu_hold !== 1'b1 || busy !== 1'b1 || bus_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_release got state=%0d cpu_rst=%b hold=%b busy=%b oe=%b want 4 1 1 1 0",
               state, cpu_rst, cpu_hold, busy, bus_oe);
    end
    @(negedge clk);
    n_tests++;
    if (state !== ST_RUN || done !== 1'b1 || cpu_hold !== 1'b0 || cpu_rst !== 1'b0 || wr_count != 0) begin
      n_fail++;
      $display("FAIL zero_run got state=%0d done=%b hold=%b cpu_rst=%b writes=%0d want 5 1 0 0 0",
               state, done, cpu_hold, cpu_rst, wr_count);
    end
  endtask

  task automatic test_reset_mid();
    logic hit;
    do_reset();
    host_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_q.push_back({AW'(0), 8'h11});
    exp_q.push_back({AW'(1), 8'h22});
    start_load(4);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      in_valid = 1'b1;
      in_data  = host_q[0];
      @(negedge clk);
      last_acc = in_valid && in_ready;
      if (last_acc) acc_count++;
      #1;
      if (state == ST_WRITE && acc_count == 2) begin
        rst = 1'b1;
        in_valid = 1'b0;
        hit = 1'b1;
      end
      @(posedge clk);
      #1;
      if (last_acc) void'(host_q.pop_front());
    end
    n_tests++;
    if (!hit) begin
      n_fail++;
      $display("FAIL midrst_timeout got hit=0 want 1");
    end
    @(negedge clk);
    n_tests++;
    if (outs !== RST_OUTS || wr_count != 2 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL midrst_outs got outs=%h writes=%0d left=%0d want %h 2 0",
               outs, wr_count, exp_q.size(), RST_OUTS);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    clear_sb();
    exp_q.push_back({AW'(0), 8'h5A});
    host_q.push_back(8'h5A);
    start_load(1);
    stream_until_done(30, "midrst_reload");
    n_tests++;
    if (wr_count != 1 || exp_q.size() != 0 || rst_pulses != 1) begin
      n_fail++;
      $display("FAIL midrst_reload got writes=%0d left=%0d cpu_rst=%0d want 1 0 1",
               wr_count, exp_q.size(), rst_pulses);
    end
  endtask

  // Global time limit
  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_sb();
    test_reset();
    test_stream3();
    test_valid_toggle();
    test_overflow();
    test_len_zero();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
